// File: rtl/mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank -- single-ported, single-clock memory bank that accepts one
// request per cycle and returns read data through a fixed-length pipeline.
//
// Parameters
//   ADDR_WIDTH   : word-address width, DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH   : word width
//   READ_LATENCY : cycles from the accept edge to t_mem_valid (1..4)
//
// Ports
//   clk          in   sole clock, rising edge
//   srst         in   synchronous active-high reset
//   i_addr       in   request word address
//   i_data       in   write data
//   i_we         in   1 = write, 0 = read
//   i_valid      in   request present
//   i_ready      out  bank accepts a request this cycle (combinational)
//   t_mem_data   out  read return data, held between returns
//   t_mem_valid  out  one-cycle pulse per returned read
//   t_mem_ready  in   return path hold-off; gates acceptance only
//
// Build option
//   MEM_BANK_CLEAR_EN : when defined, every reset is followed by a sweep that
//   writes zero to every word (DEPTH cycles, i_ready low). When undefined the
//   bank enters RUN straight after reset and contents are left undefined.
// ---------------------------------------------------------------------------
module mem_bank #(
   parameter int ADDR_WIDTH   = 11,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_we,
   input  logic                  i_valid,
   output logic                  i_ready,
   output logic [DATA_WIDTH-1:0] t_mem_data,
   output logic                  t_mem_valid,
   input  logic                  t_mem_ready
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Storage array; never touched by srst itself.
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Control shared between the two build flavours.
   logic                  run_s;        // bank is in its operating state
   logic                  clr_we_s;     // clear sweep writes this cycle
   logic [ADDR_WIDTH-1:0] clr_addr_s;   // clear sweep target address

   // Request qualification.
   logic acc_s;
   logic wr_s;
   logic rd_s;

   // Read return pipeline: stage 0 captures the array, last stage drives out.
   logic [READ_LATENCY-1:0] vld_r;
   logic [DATA_WIDTH-1:0]   dat_r [READ_LATENCY];

`ifdef MEM_BANK_CLEAR_EN
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] CLR_ONE  = ADDR_WIDTH'(1);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] clr_cnt_r;

   // State register and clear-address counter (counter saturates at DEPTH-1).
   always_ff @(posedge clk) begin
      if (srst) begin
         state_r   <= ST_CLEAR;
         clr_cnt_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_CLEAR) && (clr_cnt_r != CLR_LAST)) begin
            clr_cnt_r <= clr_cnt_r + CLR_ONE;
         end else begin
            clr_cnt_r <= clr_cnt_r;
         end
      end
   end

   // Next-state logic: leave CLEAR once the last word has been written.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_cnt_r == CLR_LAST) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_RUN:   state_nxt_s = ST_RUN;
         default:  state_nxt_s = ST_CLEAR;
      endcase
   end

   // Output decode: the sweep write is suppressed in the srst cycle so that
   // reset on its own never modifies the array.
   always_comb begin
      run_s      = 1'b0;
      clr_we_s   = 1'b0;
      clr_addr_s = clr_cnt_r;
      case (state_r)
         ST_CLEAR: begin
            run_s    = 1'b0;
            clr_we_s = ~srst;
         end
         ST_RUN: begin
            run_s    = 1'b1;
            clr_we_s = 1'b0;
         end
         default: begin
            run_s    = 1'b0;
            clr_we_s = 1'b0;
         end
      endcase
   end
`else
   assign run_s      = 1'b1;
   assign clr_we_s   = 1'b0;
   assign clr_addr_s = '0;
`endif

   // A request is only ever accepted when the bank runs, the return path is
   // open and no reset is in progress.
   assign i_ready = run_s & t_mem_ready & ~srst;
   assign acc_s   = i_valid & i_ready;
   assign wr_s    = acc_s & i_we;
   assign rd_s    = acc_s & ~i_we;

   // Array write port: clear sweep and accepted writes are mutually exclusive
   // because i_ready is low for the whole sweep.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_r[clr_addr_s] <= '0;
      end else if (wr_s) begin
         mem_r[i_addr] <= i_data;
      end
   end

   // Valid pipeline: advances every cycle, independent of t_mem_ready.
   always_ff @(posedge clk) begin
      if (srst) begin
         vld_r <= '0;
      end else begin
         vld_r[0] <= rd_s;
         for (int k = 1; k < READ_LATENCY; k++) begin
            vld_r[k] <= vld_r[k-1];
         end
      end
   end

   // Data pipeline: each stage loads only when a valid word moves into it, so
   // the last stage naturally holds the most recent returned value. A read is
   // never accepted alongside a write, so the captured word already reflects
   // every write accepted on earlier edges.
   always_ff @(posedge clk) begin
      if (srst) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            dat_r[k] <= '0;
         end
      end else begin
         if (rd_s) begin
            dat_r[0] <= mem_r[i_addr];
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            if (vld_r[k-1]) begin
               dat_r[k] <= dat_r[k-1];
            end
         end
      end
   end

   assign t_mem_valid = vld_r[READ_LATENCY-1];
   assign t_mem_data  = dat_r[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_bank.sv
// ---------------------------------------------------------------------------
// tb_mem_bank -- self-checking bench for mem_bank.
// Instance "dut" (ADDR_WIDTH=4, READ_LATENCY=2) is checked every cycle against
// a behavioural model (word array + queue of pending returns with due cycle).
// Instance "dut_b" (READ_LATENCY=3) covers reset while a read is in flight.
// Works with or without MEM_BANK_CLEAR_EN defined.
// ---------------------------------------------------------------------------
module tb_mem_bank;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int RL    = 2;
   localparam int RL_B  = 3;
`ifdef MEM_BANK_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          srst, i_we, i_valid, i_ready, t_mem_valid, t_mem_ready;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_data, t_mem_data;

   logic          b_srst, b_we, b_valid, b_ready, b_tvalid, b_tready;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data, b_tdata;

   mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
      .clk(clk), .srst(srst), .i_addr(i_addr), .i_data(i_data), .i_we(i_we),
      .i_valid(i_valid), .i_ready(i_ready), .t_mem_data(t_mem_data),
      .t_mem_valid(t_mem_valid), .t_mem_ready(t_mem_ready));

   mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL_B)) dut_b (
      .clk(clk), .srst(b_srst), .i_addr(b_addr), .i_data(b_data), .i_we(b_we),
      .i_valid(b_valid), .i_ready(b_ready), .t_mem_data(b_tdata),
      .t_mem_valid(b_tvalid), .t_mem_ready(b_tready));

   int checks   = 0;
   int failures = 0;

   // Behavioural model state.
   logic [DW-1:0] mem_m [DEPTH];
   int            clr_left = 0;
   int            edge_n   = 0;
   int            due_q [$];
   logic [DW-1:0] dat_q [$];
   logic [DW-1:0] hold_m   = '0;
   logic [DW-1:0] seen_q [$];
   logic          rdy_seen;

   typedef struct {
      logic          v;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          tr;
      logic          e_rdy;
      logic          e_vld;
      logic          chk_d;
      logic [DW-1:0] e_d;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic v, input logic we, input int a,
                        input logic [DW-1:0] d, input logic tr);
      srst        = rst;
      i_valid     = v;
      i_we        = we;
      i_addr      = AW'(a);
      i_data      = d;
      t_mem_ready = tr;
   endtask

   // One clock of dut: check ready before the edge, advance model, check outputs.
   task automatic tick();
      logic exp_rdy;
      logic acc;
      logic exp_vld;
      #1;
      exp_rdy  = (!srst && t_mem_ready && (clr_left == 0));
      rdy_seen = i_ready;
      check("i_ready", 32'(i_ready), 32'(exp_rdy));
      acc = i_valid && exp_rdy;
      @(posedge clk);
      edge_n++;
      if (srst) begin
         due_q.delete();
         dat_q.delete();
         hold_m   = '0;
         clr_left = CLEAR_EN ? DEPTH : 0;
      end else begin
         if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) foreach (mem_m[i]) mem_m[i] = '0;
         end
         if (acc) begin
            if (i_we) mem_m[i_addr] = i_data;
            else begin
               due_q.push_back(edge_n + RL - 1);
               dat_q.push_back(mem_m[i_addr]);
            end
         end
      end
      exp_vld = (due_q.size() > 0) && (due_q[0] == edge_n);
      if (exp_vld) begin
         hold_m = dat_q.pop_front();
         void'(due_q.pop_front());
      end
      #1;
      check("t_mem_valid", 32'(t_mem_valid), 32'(exp_vld));
      check("t_mem_data", t_mem_data, hold_m);
      if (t_mem_valid) seen_q.push_back(t_mem_data);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
         tick();
      end
   endtask

   task automatic b_drive(input logic rst, input logic v, input logic we, input int a,
                          input logic [DW-1:0] d);
      b_srst  = rst;
      b_valid = v;
      b_we    = we;
      b_addr  = AW'(a);
      b_data  = d;
   endtask

   function automatic vec_t mk(input logic v, input logic we, input int a, input logic [DW-1:0] d,
                               input logic tr, input logic er, input logic ev,
                               input logic cd, input logic [DW-1:0] ed);
      vec_t r;
      r.v = v; r.we = we; r.a = AW'(a); r.d = d; r.tr = tr;
      r.e_rdy = er; r.e_vld = ev; r.chk_d = cd; r.e_d = ed;
      return r;
   endfunction

   initial begin
      int cnt;
      bool_loop: begin end
      // Back-to-back write/read, hold-off of a write and of a read (RL=2).
      tbl[0]  = mk(1'b1, 1'b1, 3, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tbl[1]  = mk(1'b1, 1'b0, 3, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tbl[2]  = mk(1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
      tbl[3]  = mk(1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
      tbl[4]  = mk(1'b1, 1'b1, 5, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[5]  = mk(1'b1, 1'b1, 5, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[6]  = mk(1'b1, 1'b1, 5, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tbl[7]  = mk(1'b1, 1'b1, 5, 32'h55,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tbl[8]  = mk(1'b1, 1'b0, 5, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tbl[9]  = mk(1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h55);
      tbl[10] = mk(1'b1, 1'b0, 3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
      tbl[11] = mk(1'b1, 1'b0, 3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
      tbl[12] = mk(1'b1, 1'b0, 3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
      tbl[13] = mk(1'b1, 1'b0, 3, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tbl[14] = mk(1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
      tbl[15] = mk(1'b0, 1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001);

      b_tready = 1'b1;
      b_drive(1'b1, 1'b0, 1'b0, 0, '0);

      // Reset, then count the cycles with i_ready low (clear sweep length).
      drive(1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
      tick();
      b_drive(1'b0, 1'b0, 1'b0, 0, '0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
         tick();
         if (rdy_seen) break;
         cnt++;
      end
      check("clear_cycles", 32'(cnt), CLEAR_EN ? 32'd16 : 32'd0);

`ifdef MEM_BANK_CLEAR_EN
      // After the sweep every word reads zero.
      drive(1'b0, 1'b1, 1'b0, 7, '0, 1'b1);
      tick();
      seen_q.delete();
      idle(2);
      check("clear_read_cnt", 32'(seen_q.size()), 32'd1);
      check("clear_read7", t_mem_data, 32'h0);
`endif

      // Streaming: fill, then 16 back-to-back reads.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 1'b1, i, 32'h100 + 32'(i), 1'b1);
         tick();
      end
      seen_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 1'b0, i, '0, 1'b1);
         tick();
      end
      idle(3);
      check("stream_cnt", 32'(seen_q.size()), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         if (i < seen_q.size()) check("stream_data", seen_q[i], 32'h100 + 32'(i));
      end

      // Directed vector table.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, tbl[i].v, tbl[i].we, int'(tbl[i].a), tbl[i].d, tbl[i].tr);
         tick();
         check("tbl_ready", 32'(rdy_seen), 32'(tbl[i].e_rdy));
         check("tbl_valid", 32'(t_mem_valid), 32'(tbl[i].e_vld));
         if (tbl[i].chk_d) check("tbl_data", t_mem_data, tbl[i].e_d);
      end

      // dut_b (latency 3): normal read, then reset one cycle after a read accept.
      cnt = 0;
      while (!b_ready && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check("b_ready_timeout", 32'(b_ready), 32'd1);
      b_drive(1'b0, 1'b1, 1'b1, 1, 32'hDEAD_0001);
      @(negedge clk);
      b_drive(1'b0, 1'b1, 1'b0, 1, '0);
      @(negedge clk);
      b_drive(1'b0, 1'b0, 1'b0, 0, '0);
      @(negedge clk);
      check("b_valid_early", 32'(b_tvalid), 32'd0);
      @(negedge clk);
      check("b_valid_lat3", 32'(b_tvalid), 32'd1);
      check("b_data_lat3", b_tdata, 32'hDEAD_0001);
      b_drive(1'b0, 1'b1, 1'b0, 1, '0);
      @(negedge clk);
      check("b_valid_once", 32'(b_tvalid), 32'd0);
      b_drive(1'b1, 1'b0, 1'b0, 0, '0);
      #1;
      check("b_ready_in_srst", 32'(b_ready), 32'd0);
      @(negedge clk);
      b_drive(1'b0, 1'b0, 1'b0, 0, '0);
      for (int i = 0; i < 5; i++) begin
         check("b_no_pulse", 32'(b_tvalid), 32'd0);
         check("b_data_zero", b_tdata, 32'h0);
         @(negedge clk);
      end

      // Randomized traffic with occasional resets against the model.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
               logic'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
               $urandom(), ($urandom_range(0, 6) != 0));
         tick();
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning bank word-address width; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal 1..4, meaning accept-to-read-data cycles; equals crossbar DMA_OUT_STAGES.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port srst  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_addr  input  ADDR_WIDTH  request word address.
REQ-007 SHALL have port i_data  input  DATA_WIDTH  write data.
REQ-008 SHALL have port i_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_valid  input  1  request present.
REQ-010 SHALL have port i_ready  output  1  bank can accept request this cycle.
REQ-011 SHALL have port t_mem_data  output  DATA_WIDTH  read return data.
REQ-012 SHALL have port t_mem_valid  output  1  t_mem_data valid this cycle.
REQ-013 SHALL have port t_mem_ready  input  1  return path able to take data; global hold-off.

Function
REQ-014 SHALL accept a request on a rising edge where i_valid and i_ready are both 1; no other cycle has any effect.
REQ-015 SHALL have i_ready = (state == RUN) and t_mem_ready, purely combinational; a request held while i_ready = 0 SHALL be neither executed nor lost.
REQ-016 SHALL, on an accepted write, update mem[i_addr] with i_data at that edge and never assert t_mem_valid for it.
REQ-017 SHALL, on an accepted read, drive t_mem_valid = 1 for exactly one cycle, READ_LATENCY cycles after the accept edge, with t_mem_data = mem[i_addr] as it stands after all writes accepted on earlier edges.
REQ-018 SHALL sustain one accepted request per cycle, with any read/write mix, and return reads in acceptance order.
REQ-019 SHALL return the new data for a read accepted the cycle after a write to the same address (no stale read).
REQ-020 SHALL hold t_mem_data at the last returned read value while t_mem_valid = 0.
REQ-021 SHALL advance the read pipeline every cycle regardless of t_mem_ready; t_mem_ready gates acceptance only.
REQ-022 SHALL implement state machine states CLEAR and RUN; CLEAR -> RUN when the clear counter equals DEPTH-1; RUN is terminal until reset.
REQ-023 SHALL, in CLEAR, write zero to mem[clr_cnt] each cycle, with clr_cnt counting 0..DEPTH-1 at ADDR_WIDTH bits, and not wrap.

Reset
REQ-024 SHALL, on srst, clear every read-pipeline valid stage, so t_mem_valid = 0 from the next cycle and in-flight reads are discarded.
REQ-025 SHALL reset t_mem_data to 0, clr_cnt to 0, and state to CLEAR (macro defined) or RUN (macro undefined).
REQ-026 SHALL leave memory contents untouched by srst itself; reset mid-CLEAR restarts the sweep at address 0.
REQ-027 SHALL force i_ready = 0 during the srst cycle.

Configuration
REQ-028 SHALL, with MEM_BANK_CLEAR_EN defined, run the CLEAR sweep after every reset: i_ready = 0 for DEPTH cycles, then every word reads 0.
REQ-029 SHALL, without MEM_BANK_CLEAR_EN, omit the CLEAR state and counter, enter RUN straight after reset with memory contents undefined, and leave the interface and timing otherwise identical.

Verification
REQ-030 SHALL verify clear: ADDR_WIDTH=4, MEM_BANK_CLEAR_EN defined, srst 1 cycle -> i_ready 0 for 16 cycles, then 1; read addr 7 -> t_mem_data 0.
REQ-031 SHALL verify back-to-back: READ_LATENCY=2; write 0xA5A5_0001 to addr 3, read addr 3 next cycle -> t_mem_valid exactly 2 cycles after the read accept, data 0xA5A5_0001.
REQ-032 SHALL verify streaming: reads of addr 0..15 on 16 consecutive cycles after writing data=addr+0x100 -> 16 consecutive valid returns 0x100..0x10F, in order.
REQ-033 SHALL verify hold-off: t_mem_ready 0 for 3 cycles with i_valid 1 -> i_ready 0, no write performed, no return; the request executes once on the first cycle t_mem_ready = 1.
REQ-034 SHALL verify reset mid-flight: READ_LATENCY=3, read accepted, srst the next cycle -> no t_mem_valid pulse; t_mem_data = 0.
REQ-035 SHALL verify no-clear build: without MEM_BANK_CLEAR_EN -> i_ready 1 on the first cycle after srst deasserts; write then read returns the written value.
